uart_rx_oversample: RTL and testbench

//  UART receiver, the counterpart of the team's UART transmitter: 8N1 framing, LSB first, idle-high line.

---
 rtl/uart_rx_oversample_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx_oversample.sv | 132 +++++++++++++
 tb/tb_uart_rx_oversample.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_oversample_pkg.sv
// rtl/uart_rx_oversample_pkg.sv - shared UART state codes, defaults and counter width helper
package uart_rx_oversample_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  function automatic int cnt_w(input int oversample);
    return $clog2(oversample);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx_in synchroniser (resets to idle-high) and baud_tick rising-edge detector
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic baud_tick,
  output logic rxs,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   baud_tick_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync        <= '1;
      baud_tick_d <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], rx_in};
      baud_tick_d <= baud_tick;
    end
  end

  assign rxs  = sync[SYNC_STAGES-1];
  assign tick = baud_tick & ~baud_tick_d;

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 8N1 UART receiver with 16x oversampling, valid/ready output and error pulses
module uart_rx_oversample
  import uart_rx_oversample_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 baud_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 r_busy
);

  localparam int CNT_W  = cnt_w(OVERSAMPLE);
  localparam int BIDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

  logic                 rxs;
  logic                 tick;
  state_t               state;
  logic [CNT_W-1:0]     scnt;
  logic [CNT_W-1:0]     scnt_inc;
  logic [BIDX_W-1:0]    bidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .baud_tick(baud_tick),
    .rxs      (rxs),
    .tick     (tick)
  );

  assign scnt_inc = scnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      scnt        <= '0;
      bidx        <= '0;
      shreg       <= '0;
      armed       <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      // A completion on this same edge overrides the clear below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (tick) begin
        if (rxs) armed <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (armed && !rxs) begin
              state  <= ST_START;
              scnt   <= '0;
              armed  <= 1'b0;
              r_busy <= 1'b1;
            end
          end
          ST_START: begin
            // The detection tick is already the first low sample of the start bit.
            scnt <= scnt_inc;
            if (scnt_inc == CNT_MID) begin
              if (!rxs) begin
                state <= ST_DATA;
                scnt  <= '0;
                bidx  <= '0;
              end else begin
                state  <= ST_IDLE;
                r_busy <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            scnt <= scnt_inc;
            if (scnt == CNT_LAST) begin
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              bidx  <= bidx + BIDX_W'(1);
              if (bidx == BIDX_LAST) begin
                state <= ST_STOP;
                scnt  <= '0;
              end
            end
          end
          ST_STOP: begin
            scnt <= scnt_inc;
            if (scnt == CNT_LAST) begin
              state  <= ST_IDLE;
              r_busy <= 1'b0;
              if (rxs) begin
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun_err <= 1'b1;
                end
              end else begin
                // A line stuck low must go high again before another start is accepted.
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - directed bench for uart_rx_oversample (16 ticks/bit, tick every 4 clk)
module tb_uart_rx_oversample;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       baud_tick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       r_busy;

  int tests;
  int fails;
  int fe_cnt;
  int ov_cnt;
  int busy_seen;
  logic [7:0] got_q[$];

  uart_rx_oversample #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .baud_tick  (baud_tick),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .r_busy     (r_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (r_busy) busy_seen = 1;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  task automatic line(input logic v, input int nclk);
    rx_in = v;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_clk);
    line(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) line(d[i], BIT_CLK);
    line(stop, stop_clk);
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_counts();
    fe_cnt = 0;
    ov_cnt = 0;
    busy_seen = 0;
    got_q.delete();
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    tests++;
    if ({rx_data, rx_valid, frame_err, overrun_err, r_busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs got data=%h valid=%b fe=%b ov=%b busy=%b exp all 0",
               rx_data, rx_valid, frame_err, overrun_err, r_busy);
    end
    rst = 1'b1;
    line(1'b1, 128);
    tests++;
    if (r_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy got %b exp 0", r_busy);
    end
  endtask

  task automatic test_basic_hold();
    clear_counts();
    send_frame(8'hA5, 1'b1, BIT_CLK);
    line(1'b1, BIT_CLK);
    tests++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL t1_rx got data=%h valid=%b exp a5 1", rx_data, rx_valid);
    end
    line(1'b1, 200);
    tests++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL t1_hold got data=%h valid=%b exp a5 1", rx_data, rx_valid);
    end
    pop();
    tests++;
    if (rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL t1_consume got valid=%b exp 0", rx_valid);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    line(1'b0, 16);
    line(1'b1, 200);
    tests++;
    if (rx_valid !== 1'b0 || fe_cnt !== 0 || r_busy !== 1'b0) begin
      fails++;
      $display("FAIL t2_glitch got valid=%b fe=%0d busy=%b exp 0 0 0", rx_valid, fe_cnt, r_busy);
    end
    send_frame(8'h3C, 1'b1, BIT_CLK);
    line(1'b1, BIT_CLK);
    tests++;
    if (rx_data !== 8'h3C || rx_valid !== 1'b1 || fe_cnt !== 0) begin
      fails++;
      $display("FAIL t2_rx got data=%h valid=%b fe=%0d exp 3c 1 0", rx_data, rx_valid, fe_cnt);
    end
    pop();
  endtask

  task automatic test_frame_error();
    clear_counts();
    send_frame(8'h5A, 1'b0, BIT_CLK);
    tests++;
    if (fe_cnt !== 1 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL t3_frame_err got fe=%0d valid=%b exp 1 0", fe_cnt, rx_valid);
    end
    busy_seen = 0;
    line(1'b0, 160);
    tests++;
    if (busy_seen !== 0 || fe_cnt !== 1) begin
      fails++;
      $display("FAIL t3_stuck_low got busy_seen=%0d fe=%0d exp 0 1", busy_seen, fe_cnt);
    end
    line(1'b1, BIT_CLK);
    send_frame(8'h01, 1'b1, BIT_CLK);
    line(1'b1, BIT_CLK);
    tests++;
    if (rx_data !== 8'h01 || rx_valid !== 1'b1 || fe_cnt !== 1) begin
      fails++;
      $display("FAIL t3_recover got data=%h valid=%b fe=%0d exp 01 1 1", rx_data, rx_valid, fe_cnt);
    end
    pop();
  endtask

  task automatic test_overrun();
    clear_counts();
    send_frame(8'h11, 1'b1, BIT_CLK);
    line(1'b1, BIT_CLK);
    send_frame(8'h22, 1'b1, BIT_CLK);
    line(1'b1, BIT_CLK);
    tests++;
    if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL t4_keep_old got data=%h valid=%b exp 11 1", rx_data, rx_valid);
    end
    tests++;
    if (ov_cnt !== 1 || fe_cnt !== 0) begin
      fails++;
      $display("FAIL t4_overrun got ov=%0d fe=%0d exp 1 0", ov_cnt, fe_cnt);
    end
    pop();
    tests++;
    if (rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL t4_consume got valid=%b exp 0", rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b1, 32);
    send_frame(8'hAA, 1'b1, BIT_CLK);
    line(1'b1, BIT_CLK);
    rx_ready = 1'b0;
    tests++;
    if (got_q.size() !== 2) begin
      fails++;
      $display("FAIL t5_count got %0d bytes exp 2", got_q.size());
    end else begin
      tests++;
      if (got_q[0] !== 8'h55 || got_q[1] !== 8'hAA) begin
        fails++;
        $display("FAIL t5_order got %h %h exp 55 aa", got_q[0], got_q[1]);
      end
    end
    tests++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      fails++;
      $display("FAIL t5_errors got fe=%0d ov=%0d exp 0 0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_mid_frame_reset();
    clear_counts();
    line(1'b0, BIT_CLK);
    line(1'b1, 3 * BIT_CLK);
    tests++;
    if (r_busy !== 1'b1) begin
      fails++;
      $display("FAIL t6_busy_before got %b exp 1", r_busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({rx_data, rx_valid, frame_err, overrun_err, r_busy} !== 12'h000) begin
        fails++;
        $display("FAIL t6_in_reset got data=%h valid=%b fe=%b ov=%b busy=%b exp all 0",
                 rx_data, rx_valid, frame_err, overrun_err, r_busy);
      end
    end
    rst = 1'b1;
    clear_counts();
    line(1'b1, 128);
    send_frame(8'h0F, 1'b1, BIT_CLK);
    line(1'b1, BIT_CLK);
    tests++;
    if (rx_data !== 8'h0F || rx_valid !== 1'b1 || fe_cnt !== 0 || ov_cnt !== 0) begin
      fails++;
      $display("FAIL t6_after got data=%h valid=%b fe=%0d ov=%0d exp 0f 1 0 0",
               rx_data, rx_valid, fe_cnt, ov_cnt);
    end
    pop();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    busy_seen = 0;
    rst = 1'b0;
    rx_in = 1'b1;
    rx_ready = 1'b0;
    test_reset();
    test_basic_hold();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
